// File: rtl/lpad_lanes.sv
// Four independent lily-pad lanes: per-lane frame counter, wrap-around stepping
// and frog-on-pad collision, packaged for the frog controller and renderer.

module lpad_lane #(
  parameter int SPEED    = 8,
  parameter int DIR      = 0,
  parameter int START    = 0,
  parameter int LANE_Y   = 80,
  parameter int PAD_W    = 120,
  parameter int STEP     = 20,
  parameter int SCREEN_W = 640
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        i_active,
  input  logic        i_restart,
  input  logic [10:0] i_frog_x,
  input  logic [10:0] i_frog_y,
  output logic [10:0] o_x,
  output logic [5:0]  o_cnt,
  output logic        o_step,
  output logic        o_coll
);
  localparam logic [10:0] L_START = 11'(START);
  localparam logic [5:0]  L_LAST  = 6'((SPEED > 0) ? SPEED - 1 : 0);

  logic [10:0] r_x;
  logic [5:0]  r_cnt;
  logic        r_step;
  logic [10:0] w_x_next;
  logic [11:0] w_d;

  // Modulo-screen step; the pad never leaves 0..SCREEN_W-1.
  always_comb begin
    if (DIR != 0)
      w_x_next = (r_x >= 11'(SCREEN_W - STEP)) ? r_x + 11'(STEP) - 11'(SCREEN_W)
                                                : r_x + 11'(STEP);
    else
      w_x_next = (r_x < 11'(STEP)) ? r_x + 11'(SCREEN_W - STEP)
                                    : r_x - 11'(STEP);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x    <= L_START;
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (i_restart) begin
      r_x    <= L_START;
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (!i_active || SPEED == 0) begin
      r_step <= 1'b0;
    end else if (r_cnt == L_LAST) begin
      r_cnt  <= '0;
      r_x    <= w_x_next;
      r_step <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 6'd1;
      r_step <= 1'b0;
    end
  end

  // Distance from pad left edge to frog, wrapped so a pad straddling x=0 still hits.
  always_comb begin
    if (i_frog_x >= r_x) w_d = {1'b0, i_frog_x} - {1'b0, r_x};
    else                 w_d = {1'b0, i_frog_x} + 12'(SCREEN_W) - {1'b0, r_x};
  end

  assign o_coll = (i_frog_y == 11'(LANE_Y)) && (i_frog_x < 11'(SCREEN_W)) &&
                  (w_d <= 12'(PAD_W - 40));
  assign o_x    = r_x;
  assign o_cnt  = r_cnt;
  assign o_step = r_step;
endmodule

module lpad_lanes #(
  parameter int SPEED0 = 8,   parameter int SPEED1 = 12,
  parameter int SPEED2 = 6,   parameter int SPEED3 = 10,
  parameter int DIR0   = 0,   parameter int DIR1   = 1,
  parameter int DIR2   = 0,   parameter int DIR3   = 1,
  parameter int START0 = 0,   parameter int START1 = 200,
  parameter int START2 = 400, parameter int START3 = 100,
  parameter int LANE_Y0 = 80,  parameter int LANE_Y1 = 120,
  parameter int LANE_Y2 = 160, parameter int LANE_Y3 = 200,
  parameter int PAD_W    = 120,
  parameter int STEP     = 20,
  parameter int SCREEN_W = 640
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        active,
  input  logic        restart,
  input  logic [10:0] FrogX,
  input  logic [10:0] FrogY,
  output logic [10:0] LPad_X [0:3],
  output logic [5:0]  LPad_Speed [0:3],
  output logic [5:0]  LPad_Remainder_Count [3:0],
  output logic        LPad_Direction [0:3],
  output logic [3:0]  LPad_Step,
  output logic [3:0]  LPad_Collision
);
  localparam int NUM_LANES = 4;
  localparam int SPD [NUM_LANES] = '{SPEED0, SPEED1, SPEED2, SPEED3};
  localparam int DRN [NUM_LANES] = '{DIR0, DIR1, DIR2, DIR3};
  localparam int STX [NUM_LANES] = '{START0, START1, START2, START3};
  localparam int LNY [NUM_LANES] = '{LANE_Y0, LANE_Y1, LANE_Y2, LANE_Y3};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lpad_lane #(
      .SPEED(SPD[i]), .DIR(DRN[i]), .START(STX[i]), .LANE_Y(LNY[i]),
      .PAD_W(PAD_W), .STEP(STEP), .SCREEN_W(SCREEN_W)
    ) u_lane (
      .frame_clk(frame_clk),
      .Reset_n  (Reset_n),
      .i_active (active),
      .i_restart(restart),
      .i_frog_x (FrogX),
      .i_frog_y (FrogY),
      .o_x      (LPad_X[i]),
      .o_cnt    (LPad_Remainder_Count[i]),
      .o_step   (LPad_Step[i]),
      .o_coll   (LPad_Collision[i])
    );
    assign LPad_Speed[i]     = 6'(SPD[i]);
    assign LPad_Direction[i] = (DRN[i] != 0);
  end
endmodule

// File: tb/tb_lpad_lanes.sv
// Directed bench for lpad_lanes: collision vector tables plus hand-built
// sequences for stepping, hold, restart, async reset and right-wrap.
module tb_lpad_lanes;
  logic        frame_clk = 1'b0;
  logic        Reset_n, active, restart;
  logic [10:0] FrogX, FrogY;
  logic [10:0] x   [0:3];
  logic [5:0]  spd [0:3];
  logic [5:0]  rc  [3:0];
  logic        dir [0:3];
  logic [3:0]  step, coll;

  int checks = 0;
  int errors = 0;

  lpad_lanes dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .active(active), .restart(restart),
    .FrogX(FrogX), .FrogY(FrogY), .LPad_X(x), .LPad_Speed(spd),
    .LPad_Remainder_Count(rc), .LPad_Direction(dir),
    .LPad_Step(step), .LPad_Collision(coll)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [10:0] fx;
    logic [10:0] fy;
    logic [3:0]  exp;
    string       nm;
  } vec_t;

  vec_t tab_a [8];
  vec_t tab_w [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic run_tab(input vec_t t);
    FrogX = t.fx;
    FrogY = t.fy;
    #1;
    chk(t.nm, {28'd0, coll}, {28'd0, t.exp});
  endtask

  initial begin
    // Lanes at reset: 0@0, 1@200, 2@400, 3@100; pad covers d in 0..80.
    tab_a[0] = '{11'd400, 11'd160, 4'b0100, "l2_x400"};
    tab_a[1] = '{11'd480, 11'd160, 4'b0100, "l2_x480"};
    tab_a[2] = '{11'd481, 11'd160, 4'b0000, "l2_x481"};
    tab_a[3] = '{11'd399, 11'd160, 4'b0000, "l2_x399"};
    tab_a[4] = '{11'd400, 11'd161, 4'b0000, "l2_y161"};
    tab_a[5] = '{11'd0,   11'd80,  4'b0001, "l0_x0"};
    tab_a[6] = '{11'd180, 11'd200, 4'b1000, "l3_x180"};
    tab_a[7] = '{11'd181, 11'd200, 4'b0000, "l3_x181"};
    // Lane 0 at x=600, pad straddles the right edge.
    tab_w[0] = '{11'd620, 11'd80, 4'b0001, "wr_620"};
    tab_w[1] = '{11'd0,   11'd80, 4'b0001, "wr_0"};
    tab_w[2] = '{11'd40,  11'd80, 4'b0001, "wr_40"};
    tab_w[3] = '{11'd60,  11'd80, 4'b0000, "wr_60"};
    tab_w[4] = '{11'd599, 11'd80, 4'b0000, "wr_599"};
    tab_w[5] = '{11'd640, 11'd80, 4'b0000, "wr_640"};

    Reset_n = 1'b0; active = 1'b0; restart = 1'b0; FrogX = '0; FrogY = '0;
    #23;
    chk("rst_x0", {21'd0, x[0]}, 32'd0);
    chk("rst_x1", {21'd0, x[1]}, 32'd200);
    chk("rst_x2", {21'd0, x[2]}, 32'd400);
    chk("rst_x3", {21'd0, x[3]}, 32'd100);
    chk("rst_cnt0", {26'd0, rc[0]}, 32'd0);
    chk("rst_step", {28'd0, step}, 32'd0);
    chk("rst_coll", {28'd0, coll}, 32'd0);
    chk("spd0", {26'd0, spd[0]}, 32'd8);
    chk("spd1", {26'd0, spd[1]}, 32'd12);
    chk("dir1", {31'd0, dir[1]}, 32'd1);
    chk("dir2", {31'd0, dir[2]}, 32'd0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();
    chk("inact_x0", {21'd0, x[0]}, 32'd0);
    chk("inact_cnt0", {26'd0, rc[0]}, 32'd0);

    foreach (tab_a[i]) run_tab(tab_a[i]);
    FrogX = '0; FrogY = '0;

    // Lane 0 eight active frames: cnt 1..7 then step to 620.
    active = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("l0_cnt", {26'd0, rc[0]}, (k == 8) ? 32'd0 : k);
      chk("l0_x", {21'd0, x[0]}, (k == 8) ? 32'd620 : 32'd0);
      chk("l0_step", {31'd0, step[0]}, (k == 8) ? 32'd1 : 32'd0);
    end
    tick();
    chk("l0_step_off", {31'd0, step[0]}, 32'd0);
    chk("l0_cnt1", {26'd0, rc[0]}, 32'd1);

    // Freeze at cnt=3 for 5 frames, then 5 more frames to the step.
    tick(); tick();
    chk("hold_pre", {26'd0, rc[0]}, 32'd3);
    active = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_cnt", {26'd0, rc[0]}, 32'd3);
      chk("hold_x", {21'd0, x[0]}, 32'd620);
    end
    active = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("resume_x", {21'd0, x[0]}, (k == 5) ? 32'd600 : 32'd620);
      chk("resume_step", {31'd0, step[0]}, (k == 5) ? 32'd1 : 32'd0);
    end

    active = 1'b0;
    foreach (tab_w[i]) run_tab(tab_w[i]);
    FrogX = '0; FrogY = '0;

    // Restart at cnt=5, x=600.
    active = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("rs_pre_cnt", {26'd0, rc[0]}, 32'd5);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_x0", {21'd0, x[0]}, 32'd0);
    chk("rs_cnt0", {26'd0, rc[0]}, 32'd0);
    chk("rs_step", {28'd0, step}, 32'd0);
    chk("rs_x1", {21'd0, x[1]}, 32'd200);
    chk("rs_x2", {21'd0, x[2]}, 32'd400);
    chk("rs_x3", {21'd0, x[3]}, 32'd100);
    // Restart beats !active.
    for (int k = 0; k < 3; k++) tick();
    active = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_inact_cnt", {26'd0, rc[0]}, 32'd0);
    chk("rs_inact_cnt1", {26'd0, rc[1]}, 32'd0);

    // Async reset mid-frame.
    active = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("ar_pre_x", {21'd0, x[0]}, 32'd620);
    chk("ar_pre_cnt", {26'd0, rc[0]}, 32'd2);
    #3 Reset_n = 1'b0;
    #1;
    chk("ar_x0", {21'd0, x[0]}, 32'd0);
    chk("ar_cnt0", {26'd0, rc[0]}, 32'd0);
    chk("ar_x1", {21'd0, x[1]}, 32'd200);
    #2 Reset_n = 1'b1;

    // Lane 1 right, 24 steps of 12 frames: 620 -> 0 -> 20 -> 40.
    for (int s = 1; s <= 24; s++) begin
      for (int k = 0; k < 12; k++) tick();
      chk("l1_x", {21'd0, x[1]}, (200 + 20 * s) % 640);
      chk("l1_step", {31'd0, step[1]}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
